// File: rtl/cpu_pkg.sv
// Shared CPU definitions: sequencer state encoding, opcode constants and the reset vector.
package cpu_pkg;

   typedef enum logic [1:0] {
      FETCH,
      EXEC,
      HALTED
   } seq_state_t;

   localparam logic [5:0]  OPC_HALT             = 6'b111111;
   localparam logic [5:0]  FUNC_JR              = 6'b001000;
   localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC00000;

   // Instruction addresses are word aligned; a JR target with low bits set is illegal.
   function automatic logic is_word_aligned(input logic [1:0] low_bits);
      return low_bits == 2'b00;
   endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Fetch/execute sequencer: owns PC and IR, issues instruction reads, handles the JR branch-delay
// slot, and stops the core on halt, a misaligned JR target or a jump to address 0.
module fetch_sequencer
   import cpu_pkg::*;
#(
   parameter int unsigned          ADDR_W       = 32,
   parameter logic [ADDR_W-1:0]    RESET_VECTOR = ADDR_W'(RESET_VECTOR_DEFAULT)
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] instr_addr,
   output logic              instr_read,
   input  logic [31:0]       instr_readdata,
   input  logic              instr_waitrequest,
   output logic [31:0]       ir,
   output logic              state,
   input  logic              exec_stall,
   input  logic              branch,
   input  logic [ADDR_W-1:0] branch_target,
   input  logic              halt,
   output logic              active,
   output logic              fault,
   output logic [ADDR_W-1:0] pc
);

   seq_state_t        state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [31:0]       ir_q, ir_d;
   logic              active_q, active_d;
   logic              fault_q, fault_d;
   logic              delay_pending_q, delay_pending_d;
   logic [ADDR_W-1:0] delay_target_q, delay_target_d;

   // Next-state, next-PC and delay-slot bookkeeping.
   always_comb begin
      state_d         = state_q;
      pc_d            = pc_q;
      ir_d            = ir_q;
      active_d        = active_q;
      fault_d         = fault_q;
      delay_pending_d = delay_pending_q;
      delay_target_d  = delay_target_q;

      unique case (state_q)
         FETCH: begin
            if (!instr_waitrequest) begin
               ir_d    = instr_readdata;
               state_d = EXEC;
            end
         end

         EXEC: begin
            if (!exec_stall) begin
               if (halt) begin
                  // Halt wins over everything; any pending JR target is dropped.
                  state_d         = HALTED;
                  active_d        = 1'b0;
                  delay_pending_d = 1'b0;
               end else if (delay_pending_q) begin
                  // Delay slot finishing: apply the captured target. A JR here is illegal.
                  state_d         = FETCH;
                  pc_d            = delay_target_q;
                  delay_pending_d = 1'b0;
                  if (branch) begin
                     fault_d = 1'b1;
                  end
                  if (delay_target_q == '0) begin
                     state_d  = HALTED;
                     active_d = 1'b0;
                  end
               end else begin
                  state_d = FETCH;
                  pc_d    = pc_q + ADDR_W'(4);
                  if (branch) begin
                     if (!is_word_aligned(branch_target[1:0])) begin
                        fault_d  = 1'b1;
                        state_d  = HALTED;
                        active_d = 1'b0;
                     end else begin
                        delay_pending_d = 1'b1;
                        delay_target_d  = branch_target;
                     end
                  end
               end
            end
         end

         HALTED: begin
            // Parked until reset.
         end

         default: begin
            state_d = HALTED;
         end
      endcase
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q         <= FETCH;
         pc_q            <= RESET_VECTOR;
         ir_q            <= '0;
         active_q        <= 1'b1;
         fault_q         <= 1'b0;
         delay_pending_q <= 1'b0;
         delay_target_q  <= '0;
      end else begin
         state_q         <= state_d;
         pc_q            <= pc_d;
         ir_q            <= ir_d;
         active_q        <= active_d;
         fault_q         <= fault_d;
         delay_pending_q <= delay_pending_d;
         delay_target_q  <= delay_target_d;
      end
   end

   // Outputs come straight from registers; instr_readdata only reaches them through IR.
   always_comb begin
      instr_addr = pc_q;
      instr_read = (state_q == FETCH);
      state      = (state_q == EXEC);
      ir         = ir_q;
      active     = active_q;
      fault      = fault_q;
      pc         = pc_q;
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a driver plays memory and control decoder from a per-episode
// program, an instruction-level reference model predicts fetch addresses and final status, and a
// monitor compares every accepted fetch and every completed EXEC cycle against queued expectations.
module tb_fetch_sequencer;
   import cpu_pkg::*;

   localparam int unsigned ADDR_W = 32;
   localparam logic [31:0] RV     = 32'hBFC00000;
   localparam int          MAXI   = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] instr_addr;
   logic        instr_read;
   logic [31:0] instr_readdata = '0;
   logic        instr_waitrequest = 1'b1;
   logic [31:0] ir;
   logic        state;
   logic        exec_stall = 1'b0;
   logic        branch = 1'b0;
   logic [31:0] branch_target = '0;
   logic        halt = 1'b0;
   logic        active;
   logic        fault;
   logic [31:0] pc;

   always #5 clk = ~clk;

   fetch_sequencer #(
      .ADDR_W       (ADDR_W),
      .RESET_VECTOR (RV)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .instr_addr        (instr_addr),
      .instr_read        (instr_read),
      .instr_readdata    (instr_readdata),
      .instr_waitrequest (instr_waitrequest),
      .ir                (ir),
      .state             (state),
      .exec_stall        (exec_stall),
      .branch            (branch),
      .branch_target     (branch_target),
      .halt              (halt),
      .active            (active),
      .fault             (fault),
      .pc                (pc)
   );

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] fetch_q[$];
   logic [31:0] exec_ir_q[$];
   logic [31:0] exec_pc_q[$];
   logic [31:0] exp_hold_ir;
   bit          mon_en = 1'b0;

   // Program for one episode, indexed by execution order.
   logic [31:0] p_word[MAXI];
   logic [31:0] p_tgt[MAXI];
   int          p_wait[MAXI];
   int          p_stall[MAXI];
   bit          p_br[MAXI];
   bit          p_halt[MAXI];
   int          p_len;

   // Reference model state.
   logic [31:0] m_pc, m_tgt;
   bit          m_pend, m_fault, m_done;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // Monitor: samples just before the rising edge.
   always @(negedge clk) begin
      #3;
      if (mon_en) begin
         if (instr_read && instr_waitrequest) begin
            check("ir_hold_during_wait", ir, exp_hold_ir);
            if (fetch_q.size() != 0) check("fetch_addr_hold", instr_addr, fetch_q[0]);
         end
         if (instr_read && !instr_waitrequest) begin
            if (fetch_q.size() == 0) begin
               n_checks++;
               $display("FAIL fetch_extra: addr %h fetched, none expected (t=%0t)", instr_addr, $time);
            end else begin
               check("fetch_addr", instr_addr, fetch_q.pop_front());
            end
         end
         if (state && !exec_stall) begin
            if (exec_ir_q.size() == 0) begin
               n_checks++;
               $display("FAIL exec_extra: ir %h executed, none expected (t=%0t)", ir, $time);
            end else begin
               check("exec_ir", ir, exec_ir_q.pop_front());
               check("exec_pc", pc, exec_pc_q.pop_front());
            end
         end
      end
   end

   task automatic rand_ctrl();
      exec_stall    = 1'($urandom);
      branch        = 1'($urandom);
      halt          = 1'($urandom);
      branch_target = $urandom;
   endtask

   task automatic do_reset();
      mon_en            = 1'b0;
      rst_n             = 1'b0;
      instr_waitrequest = 1'b1;
      instr_readdata    = $urandom;
      rand_ctrl();
      @(negedge clk);
      #1;
      check("rst_pc", pc, RV);
      check("rst_addr", instr_addr, RV);
      check("rst_read", instr_read, 1'b1);
      check("rst_state", state, 1'b0);
      check("rst_ir", ir, 32'h0);
      check("rst_active", active, 1'b1);
      check("rst_fault", fault, 1'b0);
      fetch_q.delete();
      exec_ir_q.delete();
      exec_pc_q.delete();
      exp_hold_ir = '0;
      m_pc = RV; m_tgt = '0; m_pend = 0; m_fault = 0; m_done = 0;
      rst_n  = 1'b1;
      mon_en = 1'b1;
   endtask

   task automatic clear_prog(input int n);
      p_len = n;
      for (int i = 0; i < MAXI; i++) begin
         p_word[i] = $urandom; p_tgt[i] = '0; p_wait[i] = 0; p_stall[i] = 0;
         p_br[i] = 0; p_halt[i] = 0;
      end
      p_halt[n-1] = 1;
   endtask

   // Instruction-level model of one retired instruction.
   task automatic model_step(input int k);
      if (p_halt[k]) begin
         m_done = 1;
      end else if (m_pend) begin
         m_pc = m_tgt; m_pend = 0;
         if (p_br[k]) m_fault = 1;
         if (m_tgt == 32'h0) m_done = 1;
      end else begin
         m_pc = m_pc + 32'd4;
         if (p_br[k]) begin
            if (p_tgt[k][1:0] != 2'b00) begin
               m_fault = 1; m_done = 1;
            end else begin
               m_pend = 1; m_tgt = p_tgt[k];
            end
         end
      end
   endtask

   task automatic run_prog();
      for (int k = 0; k < p_len && !m_done; k++) begin
         fetch_q.push_back(m_pc);
         exec_ir_q.push_back(p_word[k]);
         exec_pc_q.push_back(m_pc);
         for (int w = 0; w < p_wait[k]; w++) begin
            instr_waitrequest = 1'b1; instr_readdata = $urandom; rand_ctrl();
            @(negedge clk);
         end
         instr_waitrequest = 1'b0; instr_readdata = p_word[k]; rand_ctrl();
         @(negedge clk);
         exp_hold_ir = p_word[k];
         for (int s = 0; s < p_stall[k]; s++) begin
            rand_ctrl(); exec_stall = 1'b1;
            instr_waitrequest = 1'($urandom); instr_readdata = $urandom;
            @(negedge clk);
         end
         exec_stall = 1'b0; branch = p_br[k]; branch_target = p_tgt[k]; halt = p_halt[k];
         instr_waitrequest = 1'($urandom); instr_readdata = $urandom;
         @(negedge clk);
         model_step(k);
      end
      #1;
      check("end_active", active, 1'b0);
      check("end_state", state, 1'b0);
      check("end_read", instr_read, 1'b0);
      check("end_pc", pc, m_pc);
      check("end_fault", fault, 32'(m_fault));
      for (int i = 0; i < 3; i++) begin
         instr_waitrequest = 1'($urandom); instr_readdata = $urandom; rand_ctrl();
         @(negedge clk);
      end
      #1;
      check("halted_pc_hold", pc, m_pc);
      check("halted_active", active, 1'b0);
      check("fetch_q_left", 32'(fetch_q.size()), 32'd0);
      check("exec_q_left", 32'(exec_ir_q.size()), 32'd0);
   endtask

   initial begin
      #100000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] tmp;
      int          r;

      // Idle memory returning ADDIU; sequential fetch then halt.
      do_reset();
      clear_prog(3);
      p_word[0] = 32'h24420001; p_word[1] = 32'h24420001;
      run_prog();

      // Reset mid-fetch with waitrequest held, then a first fetch waiting 3 cycles.
      do_reset();
      for (int i = 0; i < 2; i++) begin
         instr_waitrequest = 1'b1; instr_readdata = $urandom; rand_ctrl();
         fetch_q.push_back(RV);
         @(negedge clk);
         void'(fetch_q.pop_back());
      end
      do_reset();
      clear_prog(2);
      p_wait[0] = 3;
      run_prog();

      // JR to BFC00100 from BFC00008 with delay slot.
      do_reset();
      clear_prog(6);
      p_br[2] = 1; p_tgt[2] = 32'hBFC00100;
      run_prog();

      // JR to 0, ADDU in the delay slot, then stop.
      do_reset();
      clear_prog(6);
      p_br[0] = 1; p_tgt[0] = 32'h0; p_word[1] = 32'h00431021;
      run_prog();

      // Halt at BFC00010 after a 2-cycle stall.
      do_reset();
      clear_prog(5);
      p_stall[4] = 2;
      run_prog();

      // Branch in a delay slot: ignored, faults, pending target still applied.
      do_reset();
      clear_prog(5);
      p_br[0] = 1; p_tgt[0] = 32'hBFC00200; p_br[1] = 1; p_tgt[1] = 32'hBFC00300;
      run_prog();

      // Misaligned JR target, then reset recovers.
      do_reset();
      clear_prog(4);
      p_br[1] = 1; p_tgt[1] = 32'hBFC00102;
      run_prog();

      // Randomized programs.
      for (int ep = 0; ep < 25; ep++) begin
         do_reset();
         clear_prog($urandom_range(3, MAXI));
         for (int k = 0; k < p_len - 1; k++) begin
            p_wait[k]  = $urandom_range(0, 2);
            p_stall[k] = $urandom_range(0, 2);
            r   = $urandom_range(0, 99);
            tmp = $urandom;
            if (r < 25) begin
               p_br[k] = 1; p_tgt[k] = tmp & 32'hFFFFFFFC;
            end else if (r < 29) begin
               p_br[k] = 1; p_tgt[k] = tmp | 32'h2;
            end else if (r < 33) begin
               p_br[k] = 1; p_tgt[k] = 32'h0;
            end else if (r < 36) begin
               p_halt[k] = 1;
            end
         end
         run_prog();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
